var_delay: RTL and testbench

VAR_DELAY -- requirements
Module: var_delay

---
 rtl/nextasic_pkg.sv | 19 +
 rtl/delay_ram.sv | 40 ++++
 rtl/var_delay.sv | 107 ++++++++++
 tb/tb_var_delay.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/nextasic_pkg.sv
// Shared definitions for the variable-delay line.
//   vd_state_e  : FILL (pipeline priming after reset / delay change) and RUN.
//   clamp_delay : maps a requested delay onto the legal range 1..max_d.
package nextasic_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } vd_state_e;

  // A request of 0 becomes 1; anything above max_d saturates to max_d.
  function automatic int unsigned clamp_delay(input int unsigned sel,
                                              input int unsigned max_d);
    if (sel == 0)     return 1;
    if (sel > max_d)  return max_d;
    return sel;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Circular sample store for var_delay.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   waddr/wdata: write port, one entry {valid, data} written every cycle
//   raddr      : read address, read-before-write (same-address read returns
//                the entry written DEPTH cycles earlier)
//   rd_vld_en  : qualifies the stored valid bit as it is registered out
//   rdata      : registered read data {valid, data}
// Only the valid bits and the read register are reset; the data array is not.
module delay_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0]  raddr,
  input  logic           rd_vld_en,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_vld;

  always_ff @(posedge clk) begin
    mem_data[waddr] <= wdata[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) mem_vld        <= '0;
    else       mem_vld[waddr] <= wdata[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= {rd_vld_en & mem_vld[raddr], mem_data[raddr]};
  end

endmodule

// File: rtl/var_delay.sv
// Variable delay line: out(t+D) = in(t) with D selectable at run time.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in_data    : sample to delay, written every cycle
//   in_valid   : stored alongside the sample as its valid bit
//   delay_sel  : requested delay (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   delay_load : one-cycle strobe adopting delay_sel; restarts FILL
//   out_data   : delayed sample (registered)
//   out_valid  : delayed in_valid, forced low while filling (registered)
//   busy       : high while in FILL
//   cur_delay  : delay currently in force
module var_delay
  import nextasic_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int MAX_DELAY     = 16,
  parameter  int DEFAULT_DELAY = 4,
  localparam int DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [DW-1:0]    delay_sel,
  input  logic             delay_load,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic [DW-1:0]    cur_delay
);

  localparam int          AW   = $clog2(MAX_DELAY);
  localparam logic [DW:0] MAXV = (DW + 1)'(MAX_DELAY);

  vd_state_e       state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   raddr;
  logic [DW:0]     rsum, rsum_w;
  logic [DW-1:0]   eff_sel;
  logic            rd_vld_en;
  logic [WIDTH:0]  rdata;

  assign eff_sel = DW'(clamp_delay(32'(delay_sel), MAX_DELAY));

  // Read slot is D entries behind the write slot. Because the read is
  // registered and sees pre-write contents, a delay of D lands exactly
  // D cycles later, and D == MAX_DELAY reads the slot about to be overwritten.
  always_comb begin
    rsum   = {{(DW + 1 - AW){1'b0}}, wptr_q} + MAXV - {1'b0, dly_q};
    rsum_w = (rsum >= MAXV) ? rsum - MAXV : rsum;
    raddr  = rsum_w[AW-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    if (delay_load) begin
      // a load wins over a FILL that would otherwise complete this cycle
      state_d = ST_FILL;
      cnt_d   = eff_sel;
      dly_d   = eff_sel;
    end else if (state_q == ST_FILL) begin
      if (cnt_q <= DW'(1)) state_d = ST_RUN;
      else                 cnt_d   = cnt_q - DW'(1);
    end
  end

  // Anything emerging while the next state is FILL predates the latest
  // load/reset, so its valid bit is dropped on the way out.
  assign rd_vld_en = ~reset & (state_d == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      cnt_q   <= DW'(DEFAULT_DELAY);
      dly_q   <= DW'(DEFAULT_DELAY);
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      wptr_q  <= (wptr_q == AW'(MAX_DELAY - 1)) ? '0 : wptr_q + AW'(1);
    end
  end

  delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .waddr     (wptr_q),
    .wdata     ({in_valid, in_data}),
    .raddr     (raddr),
    .rd_vld_en (rd_vld_en),
    .rdata     (rdata)
  );

  assign out_data  = rdata[WIDTH-1:0];
  assign out_valid = rdata[WIDTH];
  assign busy      = (state_q == ST_FILL);
  assign cur_delay = dly_q;

endmodule

// File: tb/tb_var_delay.sv
// Directed bench for var_delay with a per-cycle reference model built from
// an input history and the "epoch" (cycle and delay of the latest load/reset).
module tb_var_delay;

  localparam int WIDTH = 8;
  localparam int MAX   = 16;
  localparam int DEF   = 4;
  localparam int DW    = $clog2(MAX + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    delay_sel = '0;
  logic             delay_load = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic [DW-1:0]    cur_delay;

  var_delay #(.WIDTH(WIDTH), .MAX_DELAY(MAX), .DEFAULT_DELAY(DEF)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .delay_sel  (delay_sel),
    .delay_load (delay_load),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .cur_delay  (cur_delay)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int model_clamp(input int s);
    if (s == 0)  return 1;
    if (s > MAX) return MAX;
    return s;
  endfunction

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] h_data [0:4095];
  logic             h_vld  [0:4095];
  int  cyc   = -1;
  int  ep_l  = -1;   // cycle of latest load or reset
  int  ep_d  = DEF;  // delay adopted at that cycle
  bit  ep_rst;       // epoch opened by reset (its own sample is discarded)
  bit  rst_now, e_busy, e_vld;
  int  src;

  always @(posedge clk) begin
    cyc++;
    h_data[cyc] = in_data;
    h_vld[cyc]  = in_valid;
    rst_now     = reset;
    if (reset) begin
      ep_l = cyc; ep_d = DEF; ep_rst = 1'b1;
    end else if (delay_load) begin
      ep_l = cyc; ep_d = model_clamp(int'(delay_sel)); ep_rst = 1'b0;
    end
    #1;
    if (ep_l >= 0) begin
      e_busy = (cyc - ep_l) < ep_d;
      e_vld  = 1'b0;
      src    = cyc - ep_d;
      if (!e_busy)
        e_vld = (src > ep_l || (!ep_rst && src == ep_l)) && h_vld[src];
      chk("m_busy", int'(busy), int'(e_busy));
      chk("m_cur_delay", int'(cur_delay), ep_d);
      chk("m_out_valid", int'(out_valid), int'(e_vld));
      if (rst_now)    chk("m_rst_data", int'(out_data), 0);
      else if (e_vld) chk("m_out_data", int'(out_data), int'(h_data[src]));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge: drive inputs, then return at the next negedge so
  // outputs of the intervening rising edge can be inspected.
  task automatic tick(input bit r, input bit ld, input int sel,
                      input bit v, input int d);
    reset      = r;
    delay_load = ld;
    delay_sel  = DW'(sel);
    in_valid   = v;
    in_data    = WIDTH'(d);
    @(negedge clk);
  endtask

  initial begin
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cur_delay", int'(cur_delay), 4);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);

    // single sample at default delay 4
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0);
    chk("idle_busy", int'(busy), 0);
    tick(0, 0, 0, 1, 'hA5);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    chk("a5_early", int'(out_valid), 0);
    tick(0, 0, 0, 0, 0);
    chk("a5_valid", int'(out_valid), 1);
    chk("a5_data", int'(out_data), 'hA5);
    tick(0, 0, 0, 0, 0);
    chk("a5_once", int'(out_valid), 0);

    // delay 16 with a stream wrapping the pointer several times
    tick(0, 1, 16, 1, 0);
    chk("d16_busy", int'(busy), 1);
    chk("d16_cur", int'(cur_delay), 16);
    for (int i = 1; i < 64; i++) tick(0, 0, 0, 1, i);
    chk("d16_data", int'(out_data), 47);
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0);

    // clamp low: 0 -> 1
    tick(0, 1, 0, 1, 'h11);
    chk("c0_cur", int'(cur_delay), 1);
    chk("c0_fill_valid", int'(out_valid), 0);
    tick(0, 0, 0, 1, 'h12);
    chk("c0_valid", int'(out_valid), 1);
    chk("c0_data", int'(out_data), 'h11);
    chk("c0_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 'h13 + i);

    // clamp high: 31 -> 16
    tick(0, 1, 31, 1, 'h22);
    chk("c31_cur", int'(cur_delay), 16);
    for (int i = 0; i < 15; i++) tick(0, 0, 0, 0, 0);
    chk("c31_early", int'(out_valid), 0);
    tick(0, 0, 0, 0, 0);
    chk("c31_valid", int'(out_valid), 1);
    chk("c31_data", int'(out_data), 'h22);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);

    // load 8, then load 2 three cycles later
    tick(0, 1, 8, 1, 'h30);
    tick(0, 0, 0, 1, 'h31);
    tick(0, 0, 0, 1, 'h32);
    tick(0, 1, 2, 1, 'h40);
    chk("dl_busy0", int'(busy), 1);
    chk("dl_cur", int'(cur_delay), 2);
    tick(0, 0, 0, 1, 'h41);
    chk("dl_busy1", int'(busy), 1);
    tick(0, 0, 0, 1, 'h42);
    chk("dl_busy2", int'(busy), 0);
    chk("dl_valid", int'(out_valid), 1);
    chk("dl_data", int'(out_data), 'h40);
    for (int i = 3; i < 16; i++) tick(0, 0, 0, 1, 'h40 + i);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);

    // reset mid-stream at delay 8 (load and valid asserted with it)
    tick(0, 1, 8, 1, 'h50);
    for (int i = 1; i < 12; i++) tick(0, 0, 0, 1, 'h50 + i);
    tick(1, 1, 3, 1, 'h99);
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_data", int'(out_data), 0);
    chk("mr_busy", int'(busy), 1);
    chk("mr_cur", int'(cur_delay), 4);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 'h60 + i);
    chk("mr_early", int'(out_valid), 0);
    tick(0, 0, 0, 1, 'h64);
    chk("mr_first_valid", int'(out_valid), 1);
    chk("mr_first_data", int'(out_data), 'h60);
    for (int i = 5; i < 10; i++) tick(0, 0, 0, 1, 'h60 + i);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
